// File: rtl/bp_stream_router.sv
// bp_stream_router: address-decoded host stream fan-out to per-channel FIFOs,
// plus a round-robin merge of per-channel return streams into one output register.
// Optional feature macro: BP_STREAM_ROUTER_DROP_COUNT_EN enables the saturating
// drop counter; without it drop_count_o is tied to zero.
//
// Handshakes: valid-yumi ports (stream_*_i/stream_yumi_o, ret_v_i/ret_yumi_o) mean
// the consumer asserts yumi in the same cycle it takes the beat, so yumi implies
// valid. Valid-ready ports (chan_v_o/chan_ready_i, stream_v_o/stream_ready_i) mean
// a beat moves when valid & ready are both high; valid and data hold until then.
module bp_stream_router #(
  parameter int num_channels_p = 4,
  parameter int stream_addr_width_p = 32,
  parameter int stream_data_width_p = 32,
  parameter logic [stream_addr_width_p-1:0] base_addr_p = 'h10,
  parameter logic [stream_addr_width_p-1:0] addr_stride_p = 'h10,
  parameter int fifo_els_p = 2
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         stream_v_i,
  input  logic [stream_addr_width_p-1:0]               stream_addr_i,
  input  logic [stream_data_width_p-1:0]               stream_data_i,
  output logic                                         stream_yumi_o,
  output logic [num_channels_p-1:0]                    chan_v_o,
  output logic [num_channels_p*stream_data_width_p-1:0] chan_data_o,
  input  logic [num_channels_p-1:0]                    chan_ready_i,
  input  logic [num_channels_p-1:0]                    ret_v_i,
  input  logic [num_channels_p*stream_data_width_p-1:0] ret_data_i,
  output logic [num_channels_p-1:0]                    ret_yumi_o,
  output logic                                         stream_v_o,
  output logic [stream_data_width_p-1:0]               stream_data_o,
  input  logic                                         stream_ready_i,
  output logic [15:0]                                  drop_count_o
);

  localparam int nc    = num_channels_p;
  localparam int aw    = stream_addr_width_p;
  localparam int dw    = stream_data_width_p;
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int ch_w  = (nc > 1) ? $clog2(nc) : 1;

  logic [dw-1:0]    mem_q  [nc][fifo_els_p];
  logic [dw-1:0]    mem_d  [nc][fifo_els_p];
  logic [ptr_w-1:0] wptr_q [nc];
  logic [ptr_w-1:0] wptr_d [nc];
  logic [ptr_w-1:0] rptr_q [nc];
  logic [ptr_w-1:0] rptr_d [nc];
  logic [cnt_w-1:0] cnt_q  [nc];
  logic [cnt_w-1:0] cnt_d  [nc];

  logic [ch_w-1:0]  rr_q, rr_d;
  logic             out_v_q, out_v_d;
  logic [dw-1:0]    out_data_q, out_data_d;

  logic             hit;
  logic [ch_w-1:0]  hit_idx;
  logic [nc-1:0]    full;
  logic             accept;
  logic [nc-1:0]    enq;
  logic [nc-1:0]    deq;
  logic [nc-1:0]    chan_v;
  logic             grant_v;
  logic             grant;
  logic [ch_w-1:0]  grant_idx;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Address decode: find the channel whose slot exactly matches the address.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < nc; k++) begin
      if (stream_addr_i == base_addr_p + addr_stride_p * aw'(k)) begin
        hit     = 1'b1;
        hit_idx = ch_w'(k);
      end
    end
  end

  // Input acceptance: unmapped beats are always eaten; mapped beats need room (no bypass).
  always_comb begin
    for (int k = 0; k < nc; k++) begin
      full[k] = (cnt_q[k] == cnt_w'(fifo_els_p));
    end
    accept = stream_v_i & ~reset_i & (~hit | ~full[hit_idx]);
    enq    = '0;
    if (accept & hit) enq[hit_idx] = 1'b1;
  end

  // Forward FIFO heads drive the channel outputs; a head leaves on valid & ready.
  always_comb begin
    for (int k = 0; k < nc; k++) begin
      chan_v[k]               = (cnt_q[k] != '0) & ~reset_i;
      deq[k]                  = chan_v[k] & chan_ready_i[k];
      chan_data_o[k*dw +: dw] = mem_q[k][rptr_q[k]];
    end
  end

  // Forward FIFO next state: write at wptr, read at rptr, occupancy count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < nc; k++) begin
      if (enq[k]) begin
        mem_d[k][wptr_q[k]] = stream_data_i;
        wptr_d[k]           = ptr_inc(wptr_q[k]);
      end
      if (deq[k]) rptr_d[k] = ptr_inc(rptr_q[k]);
      cnt_d[k] = cnt_q[k] + cnt_w'(enq[k]) - cnt_w'(deq[k]);
    end
  end

  // Return merge: round-robin pick starting at rr_q, loaded when the output register frees up.
  always_comb begin : arb
    logic [ch_w-1:0] cand;
    grant_v   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < nc; i++) begin
      cand = ch_w'((int'(rr_q) + i) % nc);
      if (!grant_v && ret_v_i[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
    end
    grant      = grant_v & (~out_v_q | stream_ready_i) & ~reset_i;
    ret_yumi_o = '0;
    if (grant) ret_yumi_o[grant_idx] = 1'b1;
    rr_d       = rr_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    if (grant) begin
      rr_d    = ch_w'((int'(grant_idx) + 1) % nc);
      out_v_d = 1'b1;
      for (int k = 0; k < nc; k++) begin
        if (grant_idx == ch_w'(k)) out_data_d = ret_data_i[k*dw +: dw];
      end
    end else if (out_v_q & stream_ready_i) begin
      out_v_d = 1'b0;
    end
  end

  assign stream_yumi_o = accept;
  assign chan_v_o      = chan_v;
  assign stream_v_o    = out_v_q & ~reset_i;
  assign stream_data_o = out_data_q;

  // Control state: FIFO pointers/counts, arbiter pointer, output-register valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '{default: '0};
      wptr_q  <= '{default: '0};
      rptr_q  <= '{default: '0};
      rr_q    <= '0;
      out_v_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rr_q    <= rr_d;
      out_v_q <= out_v_d;
    end
  end

  // Payload storage needs no reset; it is only visible behind a valid.
  always_ff @(posedge clk_i) begin
    mem_q      <= mem_d;
    out_data_q <= out_data_d;
  end

`ifdef BP_STREAM_ROUTER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of unmapped beats that were consumed.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept & ~hit & (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_stream_router.sv
// tb_bp_stream_router: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based transaction model of the router.
module tb_bp_stream_router;

  localparam int NCH = 4;
  localparam int DW = 32;
  localparam int FIFO_ELS = 2;
  localparam logic [31:0] BASE = 32'h10;
  localparam logic [31:0] STRIDE = 32'h10;
`ifdef BP_STREAM_ROUTER_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  logic              stream_v_i;
  logic [31:0]       stream_addr_i;
  logic [DW-1:0]     stream_data_i;
  logic              stream_yumi_o;
  logic [NCH-1:0]    chan_v_o;
  logic [NCH*DW-1:0] chan_data_o;
  logic [NCH-1:0]    chan_ready_i;
  logic [NCH-1:0]    ret_v_i;
  logic [NCH*DW-1:0] ret_data_i;
  logic [NCH-1:0]    ret_yumi_o;
  logic              stream_v_o;
  logic [DW-1:0]     stream_data_o;
  logic              stream_ready_i;
  logic [15:0]       drop_count_o;

  bp_stream_router dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .stream_v_i     (stream_v_i),
    .stream_addr_i  (stream_addr_i),
    .stream_data_i  (stream_data_i),
    .stream_yumi_o  (stream_yumi_o),
    .chan_v_o       (chan_v_o),
    .chan_data_o    (chan_data_o),
    .chan_ready_i   (chan_ready_i),
    .ret_v_i        (ret_v_i),
    .ret_data_i     (ret_data_i),
    .ret_yumi_o     (ret_yumi_o),
    .stream_v_o     (stream_v_o),
    .stream_data_o  (stream_data_o),
    .stream_ready_i (stream_ready_i),
    .drop_count_o   (drop_count_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [NCH][$];
  logic          m_out_v;
  logic [DW-1:0] m_out_data;
  int            m_rr;
  logic [15:0]   m_drop;

  logic          last_yumi;
  logic [NCH-1:0] last_ret_yumi;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_addr(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if ((off % STRIDE) != 0) return -1;
    if ((off / STRIDE) >= NCH) return -1;
    return int'(off / STRIDE);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) exp_q[k].delete();
    m_out_v    = 1'b0;
    m_out_data = '0;
    m_rr       = 0;
    m_drop     = '0;
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive at negedge, compare settled outputs, then advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] addr, input logic [DW-1:0] data,
                      input logic [NCH-1:0] cready, input logic [NCH-1:0] rv,
                      input logic [NCH*DW-1:0] rdata, input logic sready);
    int ch;
    int g;
    int idx;
    logic exp_yumi;
    logic [NCH-1:0] exp_cv;
    logic [NCH-1:0] exp_ry;
    @(negedge clk_i);
    reset_i        = 1'b0;
    stream_v_i     = v;
    stream_addr_i  = addr;
    stream_data_i  = data;
    chan_ready_i   = cready;
    ret_v_i        = rv;
    ret_data_i     = rdata;
    stream_ready_i = sready;
    #1;
    ch       = map_addr(addr);
    exp_yumi = v && (ch < 0 || exp_q[ch].size() < FIFO_ELS);
    check_eq("stream_yumi", stream_yumi_o, exp_yumi);
    for (int k = 0; k < NCH; k++) exp_cv[k] = (exp_q[k].size() > 0);
    check_eq("chan_v", chan_v_o, exp_cv);
    for (int k = 0; k < NCH; k++)
      if (exp_cv[k]) check_eq("chan_data", chan_data_o[k*DW +: DW], exp_q[k][0]);
    g = -1;
    if (!m_out_v || sready) begin
      for (int i = 0; i < NCH; i++) begin
        idx = (m_rr + i) % NCH;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    exp_ry = '0;
    if (g >= 0) exp_ry[g] = 1'b1;
    check_eq("ret_yumi", ret_yumi_o, exp_ry);
    check_eq("stream_v", stream_v_o, m_out_v);
    if (m_out_v) check_eq("stream_data", stream_data_o, m_out_data);
    check_eq("drop_count", drop_count_o, m_drop);
    last_yumi     = stream_yumi_o;
    last_ret_yumi = ret_yumi_o;
    @(posedge clk_i);
    for (int k = 0; k < NCH; k++)
      if (exp_cv[k] && cready[k]) void'(exp_q[k].pop_front());
    if (exp_yumi && ch >= 0) exp_q[ch].push_back(data);
    if (g >= 0) begin
      m_out_v    = 1'b1;
      m_out_data = rdata[g*DW +: DW];
      m_rr       = (g + 1) % NCH;
    end else if (m_out_v && sready) begin
      m_out_v = 1'b0;
    end
    if (DROP_EN && exp_yumi && ch < 0 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  // Reset held for n cycles with busy inputs; handshake outputs must stay low throughout.
  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      reset_i        = 1'b1;
      stream_v_i     = 1'b1;
      stream_addr_i  = BASE;
      ret_v_i        = '1;
      stream_ready_i = 1'b1;
      chan_ready_i   = '1;
      #1;
      check_eq("rst_yumi", stream_yumi_o, 1'b0);
      check_eq("rst_chan_v", chan_v_o, '0);
      check_eq("rst_ret_yumi", ret_yumi_o, '0);
      check_eq("rst_stream_v", stream_v_o, 1'b0);
      @(posedge clk_i);
    end
    model_reset();
  endtask

  function automatic logic [NCH*DW-1:0] ret_pattern();
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = 32'hA0 + k;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [NCH*DW-1:0] rd;
    int sel;
    reset_i = 1'b1;
    stream_v_i = 1'b0;
    stream_addr_i = '0;
    stream_data_i = '0;
    chan_ready_i = '0;
    ret_v_i = '0;
    ret_data_i = '0;
    stream_ready_i = 1'b0;
    last_yumi = 1'b0;
    last_ret_yumi = '0;
    model_reset();

    do_reset(2);

    // Unmapped drops below and above the decoded window.
    for (int i = 0; i < 5; i++)
      step(1'b1, (i % 2 == 0) ? 32'h08 : 32'h50, 32'h500 + i, '1, '0, '0, 1'b1);
    #1 check_eq("drop_total", drop_count_o, DROP_EN ? 16'd5 : 16'd0);
    check_eq("drop_no_chan_v", chan_v_o, '0);

    // In-order delivery on channel 1.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 32'h20, i, '1, '0, '0, 1'b1);
      #1 check_eq("order_ch1", chan_data_o[1*DW +: DW], i);
    end
    step(1'b0, '0, '0, '1, '0, '0, 1'b1);

    // Backpressure on channel 0, then isolation to channel 2, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 32'h100 + i, 4'b1110, '0, '0, 1'b1);
    check_eq("bp_third_stall", last_yumi, 1'b0);
    step(1'b1, 32'h30, 32'h300, 4'b1110, '0, '0, 1'b1);
    check_eq("iso_accept", last_yumi, 1'b1);
    #1 check_eq("iso_chan2_v", chan_v_o[2], 1'b1);
    step(1'b1, 32'h10, 32'h102, 4'b1111, '0, '0, 1'b1);
    check_eq("bp_no_bypass", last_yumi, 1'b0);
    step(1'b1, 32'h10, 32'h102, 4'b1111, '0, '0, 1'b1);
    check_eq("bp_release", last_yumi, 1'b1);
    repeat (3) step(1'b0, '0, '0, '1, '0, '0, 1'b1);

    // Fairness: grants rotate 0,1,2,3,0, then output holds under stall.
    do_reset(1);
    rd = ret_pattern();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, '1, '1, rd, 1'b1);
      check_eq("rr_grant", last_ret_yumi, 4'b0001 << (i % NCH));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, '1, '1, rd, 1'b0);
      #1 check_eq("stall_hold", stream_data_o, 32'hA0);
    end

    // Reset mid-stream with full FIFOs and pending output.
    for (int i = 0; i < 4; i++)
      step(1'b1, (i % 2 == 0) ? 32'h10 : 32'h20, 32'h700 + i, '0, '1, rd, 1'b0);
    step(1'b1, 32'h08, 32'h7FF, '0, '1, rd, 1'b0);
    do_reset(1);
    step(1'b0, '0, '0, '1, '1, rd, 1'b1);
    check_eq("post_rst_grant", last_ret_yumi, 4'b0001);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        sel = $urandom_range(0, 7);
        case (sel)
          4: a = 32'h08;
          5: a = 32'h50;
          6: a = 32'h18;
          7: a = $urandom;
          default: a = BASE + STRIDE * sel;
        endcase
        for (int k = 0; k < NCH; k++) rd[k*DW +: DW] = $urandom;
        step($urandom_range(0, 3) != 0, a, $urandom, NCH'($urandom),
             NCH'($urandom), rd, $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_stream_router.md
BP_STREAM_ROUTER -- requirements
Module: bp_stream_router

Interface
REQ-001 SHALL have parameter num_channels_p, default 4: number of address-decoded channels, legal range 1..16.
REQ-002 SHALL have parameter stream_addr_width_p, default 32: input stream address width.
REQ-003 SHALL have parameter stream_data_width_p, default 32: data width on all streams.
REQ-004 SHALL have parameter base_addr_p, default 32'h10: address of channel 0.
REQ-005 SHALL have parameter addr_stride_p, default 32'h10: address step between channels; power of two, nonzero.
REQ-006 SHALL have parameter fifo_els_p, default 2: per-channel forward FIFO depth, at least 2.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have ports stream_v_i, stream_addr_i, stream_data_i (input; 1, stream_addr_width_p, stream_data_width_p bits) and stream_yumi_o (output, 1 bit): host-to-device stream, valid-yumi.
REQ-010 SHALL have ports chan_v_o (output, num_channels_p), chan_data_o (output, num_channels_p*stream_data_width_p) and chan_ready_i (input, num_channels_p): per-channel forward streams, valid-ready.
REQ-011 SHALL have ports ret_v_i (input, num_channels_p), ret_data_i (input, num_channels_p*stream_data_width_p) and ret_yumi_o (output, num_channels_p): per-channel return streams, valid-yumi.
REQ-012 SHALL have ports stream_v_o (output, 1), stream_data_o (output, stream_data_width_p) and stream_ready_i (input, 1): merged device-to-host stream, valid-ready.
REQ-013 SHALL have port drop_count_o, output, 16 bits: count of dropped unmapped beats.

Function
REQ-014 SHALL map stream_addr_i to channel k when stream_addr_i == base_addr_p + k*addr_stride_p for some k < num_channels_p; every other address is unmapped.
REQ-015 SHALL assert stream_yumi_o in the same cycle as stream_v_i when the beat maps to channel k and FIFO k is not full; no bypass, so a full FIFO blocks even if it dequeues that cycle.
REQ-016 SHALL consume unmapped beats: stream_yumi_o=1 the same cycle, data discarded, never stalling the input.
REQ-017 SHALL present an accepted beat on chan_v_o[k] no earlier than the next cycle, in per-channel FIFO order; dequeue occurs when chan_v_o[k] & chan_ready_i[k].
REQ-018 SHALL let each channel drain independently; a stalled channel shall not block input beats mapped to other channels.
REQ-019 SHALL merge return streams through a one-entry output register selected by round-robin arbitration.
REQ-020 SHALL grant one requesting channel per cycle when the output register is empty or is draining that cycle (stream_v_o & stream_ready_i), asserting ret_yumi_o one-hot for the granted channel only.
REQ-021 SHALL, on a grant to channel g, set the round-robin priority to start at (g+1) mod num_channels_p.
REQ-022 SHALL hold stream_v_o and stream_data_o stable while stream_v_o=1 & stream_ready_i=0.
REQ-023 SHALL give the merged output a throughput of one beat per cycle when returns are continuously valid and stream_ready_i=1.

Reset
REQ-024 SHALL, while reset_i=1 at a clock edge, empty all FIFOs and the output register, set the round-robin pointer to 0 and clear drop_count_o.
REQ-025 SHALL hold stream_yumi_o, chan_v_o, ret_yumi_o and stream_v_o at 0 during the reset cycle.
REQ-026 SHALL discard any in-flight beat when reset occurs mid-operation; the first accept is possible in the cycle after reset deasserts.

Configuration
REQ-027 SHALL, with BP_STREAM_ROUTER_DROP_COUNT_EN defined, increment drop_count_o by 1 per dropped beat, saturating at 16'hFFFF.
REQ-028 SHALL, without BP_STREAM_ROUTER_DROP_COUNT_EN, tie drop_count_o to 0 and contain no counter logic; dropping itself is unchanged.

Verification
REQ-029 SHALL verify in-order delivery: 3 beats to addr 32'h20 with data 1, 2, 3 and chan_ready_i=4'b1111 -> chan_data_o[1] shows 1, 2, 3 in order, each one cycle after its accept.
REQ-030 SHALL verify backpressure: chan_ready_i[0]=0 and 3 beats to 32'h10 -> 2 accepted, third stalls with stream_yumi_o=0; raising chan_ready_i[0] releases it.
REQ-031 SHALL verify channel isolation: with channel 0 full, a beat to 32'h30 -> accepted the same cycle and appears on chan_v_o[2].
REQ-032 SHALL verify unmapped drops: 5 beats to 32'h08 and 32'h50 -> all yumi'd the same cycle, no chan_v_o, drop_count_o=5 (0 with macro off).
REQ-033 SHALL verify fairness: ret_v_i=4'b1111 held with stream_ready_i=1 -> grants 0, 1, 2, 3, 0 on consecutive cycles; with stream_ready_i=0, stream_data_o stays constant.
REQ-034 SHALL verify reset mid-stream: reset_i pulsed with FIFOs non-empty -> all valids 0 the next cycle, drop_count_o=0, next grant goes to channel 0.
